tap_ctrl: RTL and testbench
===========================

Name: tap_ctrl

Overview:
- IEEE 1149.1 TAP controller for the JTAG core.
- 16-state FSM clocked by TCK and steered by TMS.
- Drives the capture/shift/update strobes for the instruction register block and the data-register chain.
- Muxes the instruction-path and data-path serial outputs onto TDO, with a falling-edge-registered output enable.

Parameters:
- TDO_IDLE, 1'b0, value driven on TDO while TDO_EN is low.

Ports:
- TCK  input  1  JTAG test clock; the only clock.
- TRST_N  input  1  asynchronous, active-low reset.
- TMS  input  1  test mode select, sampled on rising TCK.
- INSTR_TDO  input  1  serial output of the instruction register.
- DATA_TDO  input  1  serial output of the selected data register.
- CAPTUREIR  output  1  high in Capture-IR.
- SHIFTIR  output  1  high in Shift-IR.
- UPDATEIR  output  1  high in Update-IR.
- CAPTUREDR  output  1  high in Capture-DR.
- SHIFTDR  output  1  high in Shift-DR.
- UPDATEDR  output  1  high in Update-DR.
- RTI  output  1  high in Run-Test/Idle.
- RESET_N  output  1  low while in Test-Logic-Reset; registered on falling TCK.
- TDO_EN  output  1  high while shifting; registered on falling TCK.
- TDO  output  1  serial test data out.
- STATE  output  4  current state encoding, for debug.

Behaviour:
- State encoding (STATE value per state):
  - TLR=F, RTI=C
  - SelDR=7, CapDR=6, ShDR=2, Ex1DR=1, PauDR=3, Ex2DR=0, UpdDR=5
  - SelIR=4, CapIR=E, ShIR=A, Ex1IR=9, PauIR=B, Ex2IR=8, UpdIR=D
- State register updates on rising TCK. Transitions are written "TMS=1 / TMS=0":
  - TLR: TLR / RTI
  - RTI: SelDR / RTI
  - SelDR: SelIR / CapDR
  - CapDR: Ex1DR / ShDR
  - ShDR: Ex1DR / ShDR
  - Ex1DR: UpdDR / PauDR
  - PauDR: Ex2DR / PauDR
  - Ex2DR: UpdDR / ShDR
  - UpdDR: SelDR / RTI
  - SelIR: TLR / CapIR
  - IR branch: identical to the DR branch (CapIR, ShIR, Ex1IR, PauIR, Ex2IR, UpdIR), with UpdIR: SelDR / RTI.
- Strobe decode (CAPTURE*/SHIFT*/UPDATE*/RTI):
  - Combinational decode of the state register only; no TMS term.
  - Changes only just after rising TCK, so a strobe is stable throughout the TCK-low phase. This keeps the instruction register's gated clock (TCK while capturing or shifting) glitch-free.
  - Downstream registers act on the rising TCK that leaves the state. Example: UPDATEIR is high during UpdIR, so the instruction latch loads on the rising edge that exits UpdIR.
- Exactly one strobe is high at a time. All strobes are low in TLR, SelDR, SelIR, Ex1/Ex2, and Pause states.
- Falling-edge registers (falling TCK):
  - RESET_N <= (state != TLR).
  - TDO_EN <= (state == ShDR) | (state == ShIR).
  - ir_sel_q <= state is in the IR branch (SelIR..UpdIR).
- TDO: combinational. TDO_EN ? (ir_sel_q ? INSTR_TDO : DATA_TDO) : TDO_IDLE.
  - INSTR_TDO is already falling-edge registered upstream; it must not be re-registered here (that would add a cycle of latency).
- Reset, TRST_N low (asynchronous, any time including mid-shift):
  - state = TLR, STATE = F.
  - RESET_N = 0, TDO_EN = 0, ir_sel_q = 0, TDO = TDO_IDLE, all strobes 0.
- Reset release: first rising TCK with TMS=0 enters RTI. RESET_N goes high on the following falling TCK.
- Synchronous recovery: TMS held high for 5 rising TCK edges reaches TLR from any state.
- No illegal states exist: all 16 codes are valid.

Test Plan:
- Reset: assert TRST_N=0 mid-ShIR with TCK running -> STATE=F immediately; TDO_EN=0; RESET_N=0; TDO=TDO_IDLE. Release, TMS=0, one TCK -> STATE=C, RTI=1; RESET_N=1 after that falling edge.
- IR scan: from RTI drive TMS 1,1,0,0, then 0 for 3 TCKs, then 1,1 -> visits SelDR, SelIR, CapIR, ShIR(x4), Ex1IR, UpdIR. Check:
  - CAPTUREIR high 1 cycle, SHIFTIR high 4 cycles, UPDATEIR high 1 cycle.
  - Instruction latch loads the 4 shifted bits (1010 shifted LSB-first -> A).
- DR scan with pause: TMS 1,0,0,0,1,0,0,1,0,0,1,1 from RTI -> ShDR, Ex1DR, PauDR(x2), Ex2DR, back to ShDR, then Ex1DR, UpdDR. Check:
  - SHIFTDR is low throughout Pause.
  - TDO_EN drops on the falling edge after leaving ShDR and returns when ShDR is re-entered.
- TDO mux: DATA_TDO=1, INSTR_TDO=0. Check:
  - In ShDR: TDO=1.
  - In ShIR: TDO=0.
  - In PauDR: TDO=TDO_IDLE (0).
  - Toggle INSTR_TDO during ShIR -> TDO follows with no added delay.
- TMS-high recovery: from each of the 16 states, hold TMS=1 for 5 TCKs -> STATE=F and RESET_N=0 after the next falling edge. From TLR, TMS=1 keeps STATE=F.
- Exhaustive transition check: for every state × TMS value, compare STATE after one rising TCK against the transition list. Strobe one-hot (or all-zero) holds every cycle.

Source files
------------

// File: rtl/tap_ctrl.sv
// ----------------------------------------------------------------------------
// tap_ctrl -- IEEE 1149.1 TAP controller for the JTAG core.
//
// This is a 16-state FSM. It is clocked by TCK and steered by TMS.
// It produces the capture/shift/update strobes for the instruction
// register and for the data-register chain. It also multiplexes the
// two serial outputs onto TDO.
//
// Ports
//   TCK        : JTAG test clock (the only clock)
//   TRST_N     : asynchronous active-low reset
//   TMS        : test mode select, sampled on rising TCK
//   INSTR_TDO  : serial output of the instruction register
//                (already falling-edge registered upstream)
//   DATA_TDO   : serial output of the selected data register
//   CAPTUREIR, SHIFTIR, UPDATEIR  : IR strobes
//   CAPTUREDR, SHIFTDR, UPDATEDR  : DR strobes
//   RTI        : high in Run-Test/Idle
//   RESET_N    : low while in Test-Logic-Reset (falling-TCK register)
//   TDO_EN     : high while shifting (falling-TCK register)
//   TDO        : serial test data out
//   STATE      : current state encoding, for debug
// ----------------------------------------------------------------------------
module tap_ctrl #(
  parameter logic TDO_IDLE = 1'b0
) (
  input  logic       TCK,
  input  logic       TRST_N,
  input  logic       TMS,
  input  logic       INSTR_TDO,
  input  logic       DATA_TDO,
  output logic       CAPTUREIR,
  output logic       SHIFTIR,
  output logic       UPDATEIR,
  output logic       CAPTUREDR,
  output logic       SHIFTDR,
  output logic       UPDATEDR,
  output logic       RTI,
  output logic       RESET_N,
  output logic       TDO_EN,
  output logic       TDO,
  output logic [3:0] STATE
);

  // All 16 codes are legal states, so there is no illegal-state recovery.
  typedef enum logic [3:0] {
    ST_TLR    = 4'hF,
    ST_RTI    = 4'hC,
    ST_SEL_DR = 4'h7,
    ST_CAP_DR = 4'h6,
    ST_SH_DR  = 4'h2,
    ST_EX1_DR = 4'h1,
    ST_PAU_DR = 4'h3,
    ST_EX2_DR = 4'h0,
    ST_UPD_DR = 4'h5,
    ST_SEL_IR = 4'h4,
    ST_CAP_IR = 4'hE,
    ST_SH_IR  = 4'hA,
    ST_EX1_IR = 4'h9,
    ST_PAU_IR = 4'hB,
    ST_EX2_IR = 4'h8,
    ST_UPD_IR = 4'hD
  } state_e;

  state_e state;
  state_e state_nxt;
  logic   ir_sel_q;

  function automatic logic in_ir_branch(input state_e s);
    case (s)
      ST_SEL_IR, ST_CAP_IR, ST_SH_IR, ST_EX1_IR,
      ST_PAU_IR, ST_EX2_IR, ST_UPD_IR: in_ir_branch = 1'b1;
      default:                         in_ir_branch = 1'b0;
    endcase
  endfunction

  // ---- rising TCK: state register ----
  always_ff @(posedge TCK or negedge TRST_N) begin
    if (!TRST_N) state <= ST_TLR;
    else         state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      ST_TLR:    state_nxt = TMS ? ST_TLR    : ST_RTI;
      ST_RTI:    state_nxt = TMS ? ST_SEL_DR : ST_RTI;
      ST_SEL_DR: state_nxt = TMS ? ST_SEL_IR : ST_CAP_DR;
      ST_CAP_DR: state_nxt = TMS ? ST_EX1_DR : ST_SH_DR;
      ST_SH_DR:  state_nxt = TMS ? ST_EX1_DR : ST_SH_DR;
      ST_EX1_DR: state_nxt = TMS ? ST_UPD_DR : ST_PAU_DR;
      ST_PAU_DR: state_nxt = TMS ? ST_EX2_DR : ST_PAU_DR;
      ST_EX2_DR: state_nxt = TMS ? ST_UPD_DR : ST_SH_DR;
      ST_UPD_DR: state_nxt = TMS ? ST_SEL_DR : ST_RTI;
      ST_SEL_IR: state_nxt = TMS ? ST_TLR    : ST_CAP_IR;
      ST_CAP_IR: state_nxt = TMS ? ST_EX1_IR : ST_SH_IR;
      ST_SH_IR:  state_nxt = TMS ? ST_EX1_IR : ST_SH_IR;
      ST_EX1_IR: state_nxt = TMS ? ST_UPD_IR : ST_PAU_IR;
      ST_PAU_IR: state_nxt = TMS ? ST_EX2_IR : ST_PAU_IR;
      ST_EX2_IR: state_nxt = TMS ? ST_UPD_IR : ST_SH_IR;
      ST_UPD_IR: state_nxt = TMS ? ST_SEL_DR : ST_RTI;
      default:   state_nxt = ST_TLR;
    endcase
  end

  // The strobes decode only the state register, so they change just after
  // rising TCK. They stay stable through the TCK-low phase, which keeps the
  // IR block's gated clock glitch-free.
  assign CAPTUREIR = (state == ST_CAP_IR);
  assign SHIFTIR   = (state == ST_SH_IR);
  assign UPDATEIR  = (state == ST_UPD_IR);
  assign CAPTUREDR = (state == ST_CAP_DR);
  assign SHIFTDR   = (state == ST_SH_DR);
  assign UPDATEDR  = (state == ST_UPD_DR);
  assign RTI       = (state == ST_RTI);
  assign STATE     = state;

  // ---- falling TCK: reset, output enable, path select ----
  always_ff @(negedge TCK or negedge TRST_N) begin
    if (!TRST_N) begin
      RESET_N  <= 1'b0;
      TDO_EN   <= 1'b0;
      ir_sel_q <= 1'b0;
    end else begin
      RESET_N  <= (state != ST_TLR);
      TDO_EN   <= (state == ST_SH_DR) || (state == ST_SH_IR);
      ir_sel_q <= in_ir_branch(state);
    end
  end

  // INSTR_TDO is already falling-edge registered upstream. Passing it
  // straight through avoids adding a cycle of shift latency.
  assign TDO = TDO_EN ? (ir_sel_q ? INSTR_TDO : DATA_TDO) : TDO_IDLE;

endmodule

// File: tb/tb_tap_ctrl.sv
module tb_tap_ctrl;

  logic       TCK, TRST_N, TMS, INSTR_TDO, DATA_TDO;
  logic       CAPTUREIR, SHIFTIR, UPDATEIR, CAPTUREDR, SHIFTDR, UPDATEDR, RTI;
  logic       RESET_N, TDO_EN, TDO;
  logic [3:0] STATE;
  logic [6:0] strb;
  logic       TDI;

  int n_chk  = 0;
  int n_pass = 0;

  tap_ctrl dut (
    .TCK(TCK), .TRST_N(TRST_N), .TMS(TMS),
    .INSTR_TDO(INSTR_TDO), .DATA_TDO(DATA_TDO),
    .CAPTUREIR(CAPTUREIR), .SHIFTIR(SHIFTIR), .UPDATEIR(UPDATEIR),
    .CAPTUREDR(CAPTUREDR), .SHIFTDR(SHIFTDR), .UPDATEDR(UPDATEDR),
    .RTI(RTI), .RESET_N(RESET_N), .TDO_EN(TDO_EN), .TDO(TDO),
    .STATE(STATE)
  );

  assign strb = {CAPTUREIR, SHIFTIR, UPDATEIR, CAPTUREDR, SHIFTDR, UPDATEDR, RTI};

  initial TCK = 1'b0;
  always #5 TCK = ~TCK;

  // Downstream instruction register model: shifts LSB-first during Shift-IR.
  // It latches on the rising edge that leaves Update-IR.
  logic [3:0] ir_sh  = 4'h0;
  logic [3:0] ir_lat = 4'h0;
  always @(posedge TCK) begin
    if (SHIFTIR)  ir_sh  <= {TDI, ir_sh[3:1]};
    if (UPDATEIR) ir_lat <= ir_sh;
  end

  typedef struct {
    logic [3:0] st;
    int         len;
    logic [7:0] path;   // TMS sequence from TLR, applied MSB-first
    logic [3:0] nx1;
    logic [3:0] nx0;
    logic [6:0] strb;   // {CIR,SIR,UIR,CDR,SDR,UDR,RTI}
  } vec_t;
  vec_t vt[16];

  task automatic chk(input string nm, input logic [7:0] act, input logic [7:0] exp);
    n_chk++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", nm, act, exp);
  endtask

  // Apply TMS/TDI, take one rising edge, and sample 1 time unit later.
  task automatic tick(input logic tms, input logic tdi = 1'b0);
    TMS = tms;
    TDI = tdi;
    @(posedge TCK);
    #1;
    chk("strobe_onehot", ($countones(strb) <= 1) ? 8'd1 : 8'd0, 8'd1);
  endtask

  task automatic fall();
    @(negedge TCK);
    #1;
  endtask

  task automatic do_reset();
    TRST_N = 1'b0;
    #1;
    TRST_N = 1'b1;
  endtask

  task automatic goto_state(input int k);
    do_reset();
    for (int i = 0; i < vt[k].len; i++) tick(vt[k].path[vt[k].len-1-i]);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "timeout");
  end

  initial begin
    logic [3:0] dr_tms_st[12];
    logic       dr_tms[12];
    logic       ir_tms[10];
    logic       ir_tdi[10];
    int         c_cap, c_sh, c_upd;

    vt[0]  = '{4'hF, 0, 8'b0,       4'hF, 4'hC, 7'b0000000};
    vt[1]  = '{4'hC, 1, 8'b0,       4'h7, 4'hC, 7'b0000001};
    vt[2]  = '{4'h7, 2, 8'b01,      4'h4, 4'h6, 7'b0000000};
    vt[3]  = '{4'h6, 3, 8'b010,     4'h1, 4'h2, 7'b0001000};
    vt[4]  = '{4'h2, 4, 8'b0100,    4'h1, 4'h2, 7'b0000100};
    vt[5]  = '{4'h1, 4, 8'b0101,    4'h5, 4'h3, 7'b0000000};
    vt[6]  = '{4'h3, 5, 8'b01010,   4'h0, 4'h3, 7'b0000000};
    vt[7]  = '{4'h0, 6, 8'b010101,  4'h5, 4'h2, 7'b0000000};
    vt[8]  = '{4'h5, 5, 8'b01011,   4'h7, 4'hC, 7'b0000010};
    vt[9]  = '{4'h4, 3, 8'b011,     4'hF, 4'hE, 7'b0000000};
    vt[10] = '{4'hE, 4, 8'b0110,    4'h9, 4'hA, 7'b1000000};
    vt[11] = '{4'hA, 5, 8'b01100,   4'h9, 4'hA, 7'b0100000};
    vt[12] = '{4'h9, 5, 8'b01101,   4'hD, 4'hB, 7'b0000000};
    vt[13] = '{4'hB, 6, 8'b011010,  4'h8, 4'hB, 7'b0000000};
    vt[14] = '{4'h8, 7, 8'b0110101, 4'hD, 4'hA, 7'b0000000};
    vt[15] = '{4'hD, 6, 8'b011011,  4'h7, 4'hC, 7'b0010000};

    TRST_N = 1'b0; TMS = 1'b1; TDI = 1'b0; INSTR_TDO = 1'b0; DATA_TDO = 1'b1;
    @(posedge TCK); #1;
    chk("por_state", {4'h0, STATE}, 8'hF);
    TRST_N = 1'b1;

    // Exhaustive transitions: every state x TMS value.
    for (int k = 0; k < 16; k++) begin
      for (int t = 0; t < 2; t++) begin
        goto_state(k);
        chk("nav_state", {4'h0, STATE}, {4'h0, vt[k].st});
        chk("strobes", {1'b0, strb}, {1'b0, vt[k].strb});
        tick(t[0]);
        chk("next_state", {4'h0, STATE}, {4'h0, (t == 1) ? vt[k].nx1 : vt[k].nx0});
      end
    end

    // TMS-high recovery from every state.
    for (int k = 0; k < 16; k++) begin
      goto_state(k);
      fall();
      for (int i = 0; i < 5; i++) tick(1'b1);
      chk("recover_state", {4'h0, STATE}, 8'hF);
      fall();
      chk("recover_reset_n", {7'h0, RESET_N}, 8'h0);
    end

    // Asynchronous reset mid Shift-IR.
    INSTR_TDO = 1'b1; DATA_TDO = 1'b1;
    goto_state(11);
    fall();
    chk("shir_tdo_en", {7'h0, TDO_EN}, 8'h1);
    TRST_N = 1'b0;
    #1;
    chk("rst_state", {4'h0, STATE}, 8'hF);
    chk("rst_tdo_en", {7'h0, TDO_EN}, 8'h0);
    chk("rst_reset_n", {7'h0, RESET_N}, 8'h0);
    chk("rst_tdo", {7'h0, TDO}, 8'h0);
    chk("rst_strobes", {1'b0, strb}, 8'h0);
    @(posedge TCK); #1;
    chk("rst_hold_state", {4'h0, STATE}, 8'hF);
    TRST_N = 1'b1;
    tick(1'b0);
    chk("rel_state", {4'h0, STATE}, 8'hC);
    chk("rel_rti", {7'h0, RTI}, 8'h1);
    chk("rel_reset_n_pre", {7'h0, RESET_N}, 8'h0);
    fall();
    chk("rel_reset_n_post", {7'h0, RESET_N}, 8'h1);

    // IR scan: shift 1010 LSB-first and expect A in the latch.
    ir_tms = '{1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0};
    ir_tdi = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0};
    c_cap = 0; c_sh = 0; c_upd = 0;
    for (int i = 0; i < 10; i++) begin
      tick(ir_tms[i], ir_tdi[i]);
      c_cap += int'(CAPTUREIR);
      c_sh  += int'(SHIFTIR);
      c_upd += int'(UPDATEIR);
    end
    chk("ir_cap_cycles", c_cap[7:0], 8'd1);
    chk("ir_shift_cycles", c_sh[7:0], 8'd4);
    chk("ir_upd_cycles", c_upd[7:0], 8'd1);
    chk("ir_latch", {4'h0, ir_lat}, 8'hA);
    chk("ir_end_state", {4'h0, STATE}, 8'hC);

    // DR scan with pause; DATA_TDO=1, INSTR_TDO=0.
    INSTR_TDO = 1'b0; DATA_TDO = 1'b1;
    dr_tms    = '{1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b1, 1'b1};
    dr_tms_st = '{4'h7, 4'h6, 4'h2, 4'h2, 4'h1, 4'h3, 4'h3, 4'h0, 4'h2, 4'h2, 4'h1, 4'h5};
    for (int i = 0; i < 12; i++) begin
      tick(dr_tms[i]);
      chk("dr_state", {4'h0, STATE}, {4'h0, dr_tms_st[i]});
      chk("dr_shiftdr", {7'h0, SHIFTDR}, {7'h0, (dr_tms_st[i] == 4'h2)});
      fall();
      chk("dr_tdo_en", {7'h0, TDO_EN}, {7'h0, (dr_tms_st[i] == 4'h2)});
      chk("dr_tdo", {7'h0, TDO}, {7'h0, (dr_tms_st[i] == 4'h2)});
    end

    // TDO follows INSTR_TDO in Shift-IR with no added delay.
    goto_state(11);
    fall();
    chk("shir_tdo0", {7'h0, TDO}, 8'h0);
    INSTR_TDO = 1'b1; #1;
    chk("shir_tdo1", {7'h0, TDO}, 8'h1);
    INSTR_TDO = 1'b0; #1;
    chk("shir_tdo2", {7'h0, TDO}, 8'h0);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
